// File: rtl/muldiv_sequencer_pkg.sv
// Shared lc3b types for the EX-stage multiply/divide sequencer.
package muldiv_sequencer_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } lc3b_muldiv_op;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline <-> mul/div sequencer handshake; master is the pipeline, slave the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 16
);
  import muldiv_sequencer_pkg::*;

  logic              start;
  lc3b_muldiv_op     op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              pipe_stalled;
  logic              stall_req;
  logic              busy;
  logic [WIDTH-1:0]  result;
  logic              result_valid;
  logic              div_zero;

  modport master (
    output start, op, a, b, pipe_stalled,
    input  stall_req, busy, result, result_valid, div_zero
  );

  modport slave (
    input  start, op, a, b, pipe_stalled,
    output stall_req, busy, result, result_valid, div_zero
  );

endinterface

// File: rtl/muldiv_sequencer_iter.sv
// Iterative shift-add multiply / restoring divide datapath, one step per i_step.
module muldiv_iter_dp
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  lc3b_muldiv_op     i_op,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_next_result
);

  // r_acc: product or partial remainder; r_opnd: multiplicand or divisor;
  // r_shift: multiplier or dividend/quotient shift register.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_shift;
  lc3b_muldiv_op    r_op;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_opnd_nx;
  logic [WIDTH-1:0] w_shift_nx;

  always_comb begin
    w_trial    = {r_acc, r_shift[WIDTH-1]} - {1'b0, r_opnd};
    w_acc_nx   = r_acc;
    w_opnd_nx  = r_opnd;
    w_shift_nx = r_shift;
    if (r_op == MD_MUL) begin
      if (r_shift[0]) w_acc_nx = r_acc + r_opnd;
      w_opnd_nx  = r_opnd << 1;
      w_shift_nx = r_shift >> 1;
    end else if (w_trial[WIDTH]) begin
      w_acc_nx   = {r_acc[WIDTH-2:0], r_shift[WIDTH-1]};
      w_shift_nx = {r_shift[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nx   = w_trial[WIDTH-1:0];
      w_shift_nx = {r_shift[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    o_next_result = w_acc_nx;
    if (r_op == MD_DIVU) o_next_result = w_shift_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_shift <= '0;
      r_op    <= MD_MUL;
    end else if (i_load) begin
      r_acc   <= '0;
      r_op    <= i_op;
      r_opnd  <= (i_op == MD_MUL) ? i_a : i_b;
      r_shift <= (i_op == MD_MUL) ? i_b : i_a;
    end else if (i_step) begin
      r_acc   <= w_acc_nx;
      r_opnd  <= w_opnd_nx;
      r_shift <= w_shift_nx;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage mul/div sequencer: FSM + step counter around muldiv_iter_dp.
// Optional MULDIV_DZ_FAST_EN: divide-by-zero skips iteration and flags div_zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_sequencer_if.slave     bus
);

  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_dp_result;

  assign w_load = (r_state == IDLE) && bus.start;
  assign w_step = (r_state == RUN);
  assign w_last = w_step && (r_count == CNT_W'(ITERS - 1));

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_op          (bus.op),
    .i_a           (bus.a),
    .i_b           (bus.b),
    .o_next_result (w_dp_result)
  );

`ifdef MULDIV_DZ_FAST_EN
  logic w_fast;
  logic r_dz;
  assign w_fast = w_load && (bus.op != MD_MUL) && (bus.b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_dz <= 1'b0;
    else if (w_load) r_dz <= w_fast;
  end

  assign bus.div_zero = r_dz && (r_state == DONE);
`else
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
`ifdef MULDIV_DZ_FAST_EN
          if (w_fast) begin
            r_state  <= DONE;
            r_result <= (bus.op == MD_DIVU) ? '1 : bus.a;
          end else
`endif
          begin
            r_state <= RUN;
            r_count <= '0;
          end
        end
        RUN: begin
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_result <= w_dp_result;
            r_state  <= DONE;
          end
        end
        DONE: if (!bus.pipe_stalled) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // stall_req follows start combinationally in IDLE so EX is held the same cycle
  assign bus.stall_req    = rst_n && (w_load || (r_state == RUN));
  assign bus.busy         = (r_state != IDLE);
  assign bus.result_valid = (r_state == DONE);
  assign bus.result       = r_result;

endmodule
